// File: rtl/alu_lock_arbiter.sv
// Single-owner ALU lock arbiter for NUM_SIC requesters: the oldest issue id wins,
// and the lock passes to the next owner on release with no idle cycle.
module alu_lock_arbiter #(
    parameter int NUM_SIC  = 4,
    parameter int ID_WIDTH = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SIC-1:0]                req,
    input  logic [NUM_SIC-1:0][ID_WIDTH-1:0]  req_issue_id,
    input  logic [NUM_SIC-1:0]                release_lock,
    input  logic                              flush,
    output logic [NUM_SIC-1:0]                grant,
    output logic                              owner_valid,
    output logic [$clog2(NUM_SIC)-1:0]        owner_idx,
    output logic                              proto_err
);
    localparam int IDX_W = $clog2(NUM_SIC);

    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [NUM_SIC-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic               proto_err_reg, proto_err_next;

    logic [NUM_SIC-1:0] eligible;
    logic [NUM_SIC-1:0] beats_all;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               owner_release;
    logic               owner_abandon;
    logic               stray_release;

    // a is older than b when (a - b) mod 2^ID_WIDTH has its top bit set
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a,
                                      input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    assign owner_release = (state_reg == HELD) && release_lock[owner_reg];
    assign owner_abandon = (state_reg == HELD) && !req[owner_reg] && !release_lock[owner_reg];
    assign stray_release = |(release_lock & ~grant_reg);

    for (genvar gi = 0; gi < NUM_SIC; gi++) begin : g_sic
        logic beat;

        assign eligible[gi] = req[gi] && !(owner_release && (owner_reg == IDX_W'(gi)));

        always_comb begin
            beat = eligible[gi];
            for (int j = 0; j < NUM_SIC; j++) begin
                if (j != gi && eligible[j]) begin
                    if (req_issue_id[j] == req_issue_id[gi]) begin
                        if (j < gi) beat = 1'b0;
                    end else if (!is_older(req_issue_id[gi], req_issue_id[j])) begin
                        beat = 1'b0;
                    end
                end
            end
        end

        assign beats_all[gi] = beat;
    end

    // Ids spread over more than half the id space have no strict oldest; falling back
    // to the lowest eligible index keeps the lock from stalling in that case.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_SIC - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = IDX_W'(i);
        end
        for (int i = NUM_SIC - 1; i >= 0; i--) begin
            if (beats_all[i]) win_idx = IDX_W'(i);
        end
    end

    assign win_valid = |eligible;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            owner_reg     <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            owner_reg     <= owner_next;
            proto_err_reg <= proto_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        owner_next     = owner_reg;
        // A flush legitimately drops requests, so it never counts as abandonment
        proto_err_next = proto_err_reg | stray_release | (owner_abandon && !flush);
        if (flush) begin
            state_next = IDLE;
            grant_next = '0;
            owner_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        state_next = HELD;
                        grant_next = NUM_SIC'(1) << win_idx;
                        owner_next = win_idx;
                    end
                end
                HELD: begin
                    if (owner_release || owner_abandon) begin
                        if (win_valid) begin
                            grant_next = NUM_SIC'(1) << win_idx;
                            owner_next = win_idx;
                        end else begin
                            state_next = IDLE;
                            grant_next = '0;
                            owner_next = '0;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    grant_next = '0;
                    owner_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        grant       = grant_reg;
        owner_idx   = owner_reg;
        owner_valid = (state_reg == HELD);
        proto_err   = proto_err_reg;
    end

endmodule

// File: tb/tb_alu_lock_arbiter.sv
// Vector-table bench for alu_lock_arbiter: each step drives one cycle of inputs,
// queues the expected registered outputs and checks them just after the next edge.
module tb_alu_lock_arbiter;
    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [3:0]           req = '0;
    logic [3:0][5:0]      req_issue_id = '0;
    logic [3:0]           release_lock = '0;
    logic                 flush = 1'b0;
    logic [3:0]           grant;
    logic                 owner_valid;
    logic [1:0]           owner_idx;
    logic                 proto_err;

    typedef struct {
        logic            rst_n;
        logic [3:0]      req;
        logic [3:0][5:0] ids;
        logic [3:0]      rel;
        logic            flush;
        logic [3:0]      g;
        logic            v;
        logic [1:0]      idx;
        logic            p;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic       v;
        logic [1:0] idx;
        logic       p;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    alu_lock_arbiter #(.NUM_SIC(4), .ID_WIDTH(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_issue_id (req_issue_id),
        .release_lock (release_lock),
        .flush        (flush),
        .grant        (grant),
        .owner_valid  (owner_valid),
        .owner_idx    (owner_idx),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [3:0][5:0] ids4(input int a, input int b, input int c, input int d);
        logic [3:0][5:0] r;
        r[0] = 6'(a);
        r[1] = 6'(b);
        r[2] = 6'(c);
        r[3] = 6'(d);
        return r;
    endfunction

    function automatic vec_t mk(input logic rs, input logic [3:0] rq, input logic [3:0][5:0] id,
                                input logic [3:0] rl, input logic fl, input logic [3:0] g,
                                input logic v, input logic [1:0] idx, input logic p);
        vec_t t;
        t.rst_n = rs; t.req = rq; t.ids = id; t.rel = rl; t.flush = fl;
        t.g = g; t.v = v; t.idx = idx; t.p = p;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL txn%0d %s: got=%0h want=%0h", txn, nm, act, exp);
        end
    endtask

    task automatic step(input vec_t t);
        exp_t e;
        @(negedge clk);
        rst_n        = t.rst_n;
        req          = t.req;
        req_issue_id = t.ids;
        release_lock = t.rel;
        flush        = t.flush;
        sb.push_back('{g: t.g, v: t.v, idx: t.idx, p: t.p});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        $display("txn %0d rst_n=%b req=%b rel=%b flush=%b -> grant=%b valid=%b idx=%0d perr=%b",
                 txn, t.rst_n, t.req, t.rel, t.flush, grant, owner_valid, owner_idx, proto_err);
        chk("grant",       8'(grant),       8'(e.g));
        chk("owner_valid", 8'(owner_valid), 8'(e.v));
        chk("owner_idx",   8'(owner_idx),   8'(e.idx));
        chk("proto_err",   8'(proto_err),   8'(e.p));
        txn++;
    endtask

    vec_t tbl[17];
    logic [3:0][5:0] z;

    initial begin
        z = '0;
        //            rst  req      ids                  rel      fl    grant    v     idx    perr
        tbl[0]  = mk(1'b0, 4'b0000, z,                   4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        tbl[1]  = mk(1'b1, 4'b0000, z,                   4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        tbl[2]  = mk(1'b1, 4'b1110, ids4(0, 10, 7, 12),  4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        tbl[3]  = mk(1'b1, 4'b1111, ids4(1, 2, 3, 4),    4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        tbl[4]  = mk(1'b1, 4'b1100, z,                   4'b0100, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        tbl[5]  = mk(1'b1, 4'b1000, z,                   4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        tbl[6]  = mk(1'b1, 4'b0011, ids4(62, 1, 0, 0),   4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        tbl[7]  = mk(1'b1, 4'b0111, ids4(0, 5, 5, 0),    4'b0001, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        tbl[8]  = mk(1'b1, 4'b0110, z,                   4'b0010, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        tbl[9]  = mk(1'b1, 4'b1100, z,                   4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        tbl[10] = mk(1'b1, 4'b1100, ids4(0, 0, 20, 19),  4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        tbl[11] = mk(1'b0, 4'b1100, ids4(0, 0, 20, 19),  4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        tbl[12] = mk(1'b1, 4'b1100, ids4(0, 0, 20, 19),  4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        tbl[13] = mk(1'b0, 4'b0000, z,                   4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        tbl[14] = mk(1'b1, 4'b0001, z,                   4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        tbl[15] = mk(1'b1, 4'b0001, z,                   4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        tbl[16] = mk(1'b0, 4'b0000, z,                   4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);

        for (int i = 0; i < 17; i++) step(tbl[i]);

        // Non-owner release: grant holds, error flag sticks from the next cycle on
        step(mk(1'b1, 4'b0100, z, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0));
        step(mk(1'b1, 4'b0110, z, 4'b0010, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1));
        step(mk(1'b1, 4'b0110, z, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1));
        step(mk(1'b0, 4'b0000, z, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0));

        // Abandoned lock, then error flag survives re-grant and flush
        step(mk(1'b1, 4'b0001, z, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0));
        step(mk(1'b1, 4'b0000, z, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1));
        step(mk(1'b1, 4'b0000, z, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1));
        step(mk(1'b1, 4'b0010, z, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1));
        step(mk(1'b1, 4'b0010, z, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1));
        step(mk(1'b0, 4'b0000, z, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
